data_stack: RTL

Data stack for the 16-bit stack processor, directly downstream of the instruction decoder. On each rising edge it executes the decoder's `stackOP` command, and its write value comes from the `stackControl`-selected mux (immediate, LUI immediate, memory, ALU or input). It presents the top two entries to the ALU and the memory/PC paths. It also tracks occupancy and flags overflow and underflow without corrupting its contents.

---
 rtl/data_stack.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_stack.sv
// data_stack: 16-bit stack processor data stack.
// In: CLK, reset(n), stackOP, din, clear_err. Out: top, second, count, empty, full, overflow, underflow.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [2:0]                 stackOP,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_PAR  = 3'd2,
    OP_POP  = 3'd3,
    OP_POP2 = 3'd4,
    OP_SWAP = 3'd5
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic has1, has2, is_full;
  logic do_push, do_par, do_pop, do_pop2, do_swap;
  logic f_ovf, f_unf;

  assign has1    = (cnt_q >= ONE);
  assign has2    = (cnt_q >= TWO);
  assign is_full = (cnt_q == DMAX);

  always_comb begin
    do_push = 1'b0;
    do_par  = 1'b0;
    do_pop  = 1'b0;
    do_pop2 = 1'b0;
    do_swap = 1'b0;
    f_ovf   = 1'b0;
    f_unf   = 1'b0;
    case (stackOP)
      OP_PUSH: begin
        do_push = !is_full;
        f_ovf   = is_full;
      end
      OP_PAR: begin
        do_par = has2;
        f_unf  = !has2;
      end
      OP_POP: begin
        do_pop = has1;
        f_unf  = !has1;
      end
      OP_POP2: begin
        do_pop2 = has2;
        f_unf   = !has2;
      end
      OP_SWAP: begin
        do_swap = has2;
        f_unf   = !has2;
      end
      default: ;
    endcase
  end

  // Storage is a shift register: entry 0 is always the top, so
  // deeper entries keep their relative order under every command.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
      cnt_d = cnt_q + ONE;
    end else if (do_par) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - ONE;
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - ONE;
    end else if (do_pop2) begin
      for (int i = 0; i < DEPTH - 2; i++) mem_d[i] = mem_q[i+2];
      mem_d[DEPTH-2] = '0;
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - TWO;
    end else if (do_swap) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[0];
    end
  end

  // A fault raised in the same cycle as clear_err still sets its flag.
  always_comb begin
    ovf_d = clear_err ? 1'b0 : ovf_q;
    unf_d = clear_err ? 1'b0 : unf_q;
    if (f_ovf) ovf_d = 1'b1;
    if (f_unf) unf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign top       = has1 ? mem_q[0] : '0;
  assign second    = has2 ? mem_q[1] : '0;
  assign count     = cnt_q;
  assign empty     = (cnt_q == '0);
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
